// File: rtl/ci_initiator.sv
// ci_initiator: issues one operand pair to a multi-cycle custom-instruction unit,
// waits for ci_done with a timeout, and holds the result until the consumer takes it.
module ci_initiator #(
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_dataa,
    input  logic [31:0] req_datab,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        ci_clk_en,
    output logic        ci_start,
    output logic        ci_reset,
    output logic [31:0] ci_dataa,
    output logic [31:0] ci_datab,
    input  logic [31:0] ci_result,
    input  logic        ci_done,
    output logic [15:0] stat_done,
    output logic [15:0] stat_timeout
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ABORT, RESP} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] opa, opb;
    assign ci_dataa = opa;
    assign ci_datab = opb;
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_timeout  <= 1'b0;
            rsp_data     <= '0;
            ci_clk_en    <= 1'b0;
            ci_start     <= 1'b0;
            ci_reset     <= 1'b0;
            opa          <= '0;
            opb          <= '0;
            cnt          <= '0;
            stat_done    <= '0;
            stat_timeout <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    opa       <= req_dataa;
                    opb       <= req_datab;
                    req_ready <= 1'b0;
                    ci_start  <= 1'b1;
                    ci_clk_en <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    cnt      <= '0;
                    ci_start <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    // a done on the final allowed cycle still wins over the timeout
                    if (ci_done) begin
                        rsp_data    <= ci_result;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        ci_clk_en   <= 1'b0;
                        stat_done   <= stat_done + {15'd0, stat_done != 16'hFFFF};
                        state       <= RESP;
                    end else if (cnt == LAST) begin
                        ci_clk_en    <= 1'b0;
                        ci_reset     <= 1'b1;
                        stat_timeout <= stat_timeout + {15'd0, stat_timeout != 16'hFFFF};
                        state        <= ABORT;
                    end
                end
                ABORT: begin
                    ci_reset    <= 1'b0;
                    rsp_data    <= '0;
                    rsp_timeout <= 1'b1;
                    rsp_valid   <= 1'b1;
                    state       <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ci_initiator.sv
// tb_ci_initiator: scoreboard bench for ci_initiator with a behavioural unit model
// whose done latency is chosen per operation (0 = never done).
module tb_ci_initiator;
    localparam int TIMEOUT = 32;
    logic        clk = 0, reset = 1, req_valid = 0, rsp_ready = 0, ci_done = 0;
    logic [31:0] req_dataa = 0, req_datab = 0, ci_result = 0;
    logic        req_ready, rsp_valid, rsp_timeout, ci_clk_en, ci_start, ci_reset;
    logic [31:0] rsp_data, ci_dataa, ci_datab;
    logic [15:0] stat_done, stat_timeout;
    typedef struct {logic [31:0] data; logic to;} rsp_t;
    rsp_t        sb[$];
    int          n_cmp = 0, n_bad = 0, lat = 0, since = 0, waits = 0, aborts = 0;
    logic        noise = 0;
    logic [15:0] exp_done = 0, exp_to = 0;

    ci_initiator #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_dataa(req_dataa), .req_datab(req_datab), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .ci_clk_en(ci_clk_en), .ci_start(ci_start), .ci_reset(ci_reset),
        .ci_dataa(ci_dataa), .ci_datab(ci_datab), .ci_result(ci_result),
        .ci_done(ci_done), .stat_done(stat_done), .stat_timeout(stat_timeout)
    );

    always #5 clk = ~clk;

    // unit model: done after lat enabled cycles; noise drives done while the unit is idle
    always @(negedge clk) begin
        if (ci_start) since = 0;
        else if (ci_clk_en) since = since + 1;
        ci_done = (ci_clk_en && !ci_start) ? (lat > 0 && since == lat) : noise;
        ci_result = ci_dataa + ci_datab;
        if (ci_clk_en && !ci_start) waits++;
        if (ci_reset) aborts++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return v == 16'hFFFF ? v : v + 16'd1;
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int l, input int hold);
        int n, w0, a0;
        rsp_t e;
        logic [31:0] d0;
        bit ok;
        @(negedge clk);
        req_valid = 1; req_dataa = a; req_datab = b; lat = l;
        ok = (l > 0 && l <= TIMEOUT);
        sb.push_back('{data: ok ? a + b : 32'd0, to: !ok});
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) check("accept", 0, 1);
        @(negedge clk);
        req_valid = 0;
        check("start", ci_start, 1);
        check("operands", {ci_dataa ^ a} | {ci_datab ^ b}, 0);
        w0 = waits; a0 = aborts;
        n = 0;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        check("latency", n, ok ? l + 1 : TIMEOUT + 2);
        check("wait_cycles", waits - w0, ok ? l : TIMEOUT);
        check("ci_reset_pulses", aborts - a0, ok ? 0 : 1);
        d0 = rsp_data;
        repeat (hold) begin
            @(negedge clk);
            check("hold", {rsp_valid, req_ready, rsp_data == d0}, 3'b101);
        end
        rsp_ready = 1;
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_timeout", rsp_timeout, e.to);
        if (ok) exp_done = sat_inc(exp_done);
        else exp_to = sat_inc(exp_to);
        @(negedge clk);
        rsp_ready = 0;
        check("back_to_idle", {req_ready, rsp_valid}, 2'b10);
        check("stat_done", stat_done, exp_done);
        check("stat_timeout", stat_timeout, exp_to);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {req_ready, rsp_valid, rsp_timeout, ci_start, ci_clk_en, ci_reset}, 6'b100000);
        check("reset_regs", rsp_data | ci_dataa | ci_datab, 0);
        check("reset_stats", {stat_done, stat_timeout}, 0);
        reset = 0;
        // reset during the second WAIT cycle
        @(negedge clk);
        req_valid = 1; req_dataa = 32'h11; req_datab = 32'h22; lat = 0;
        @(negedge clk);
        req_valid = 0;
        repeat (2) @(negedge clk);
        check("mid_wait_en", ci_clk_en, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("mid_wait_reset", {req_ready, ci_clk_en, rsp_valid}, 3'b100);
        check("mid_wait_stats", {stat_done, stat_timeout}, 0);
        seen = 0;
        repeat (40) begin @(negedge clk); seen |= int'(rsp_valid); end
        check("mid_wait_no_rsp", seen, 0);
        do_op(32'h5, 32'h7, 3, 0);
        do_op(32'hFFFF_FFFF, 32'h2, 1, 0);
        do_op(32'h1234, 32'h1, 0, 0);
        do_op(32'hA5A5_0000, 32'h0000_5A5A, 5, 10);
        do_op(32'h100, 32'h200, TIMEOUT, 0);
        do_op(32'h300, 32'h400, TIMEOUT + 1, 2);
        noise = 1;
        do_op(32'hDEAD_0000, 32'hBEEF, 2, 3);
        do_op(32'h7, 32'h8, 0, 1);
        noise = 0;
        for (int i = 0; i < 6; i++)
            do_op($urandom, $urandom, $urandom_range(0, 40), $urandom_range(0, 3));
        @(negedge clk);
        force dut.stat_done = 16'hFFFE;
        @(negedge clk);
        release dut.stat_done;
        exp_done = 16'hFFFE;
        do_op(32'h1, 32'h1, 2, 0);
        do_op(32'h2, 32'h2, 4, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ci_initiator.md
CI_INITIATOR -- requirements
Module: ci_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32, giving the maximum number of WAIT cycles allowed for ci_done (legal 2..255).
REQ-002 SHALL have clk, input, 1, the clock; all logic is rising-edge.
REQ-003 SHALL have reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have req_valid, input, 1, an operand pair is offered.
REQ-005 SHALL have req_ready, output, 1, the block accepts an operand pair.
REQ-006 SHALL have req_dataa and req_datab, input, 32 each, the operands.
REQ-007 SHALL have rsp_valid, output, 1, a response is held.
REQ-008 SHALL have rsp_ready, input, 1, the consumer accepts the response.
REQ-009 SHALL have rsp_data, output, 32, the captured result, or 0 on timeout.
REQ-010 SHALL have rsp_timeout, output, 1, the response came from a timeout.
REQ-011 SHALL have ci_clk_en, ci_start and ci_reset, output, 1 each, driving the multi-cycle custom-instruction unit.
REQ-012 SHALL have ci_dataa and ci_datab, output, 32 each, the unit operands.
REQ-013 SHALL have ci_result, input, 32, and ci_done, input, 1, from the unit.
REQ-014 SHALL have stat_done and stat_timeout, output, 16 each, saturating event counters.

Function
REQ-015 SHALL implement the states IDLE, ISSUE, WAIT, ABORT and RESP, and no others.
REQ-016 IDLE SHALL drive req_ready=1; all other states SHALL drive req_ready=0.
REQ-017 IDLE with req_valid=1 SHALL register req_dataa and req_datab and go to ISSUE.
REQ-018 ISSUE SHALL last exactly one cycle with ci_start=1 and ci_clk_en=1, clear the wait counter, and go to WAIT.
REQ-019 ci_dataa and ci_datab SHALL be the registered operands and SHALL stay stable from ISSUE to the end of WAIT.
REQ-020 ci_clk_en SHALL be 1 in ISSUE and in every WAIT cycle, and 0 in IDLE, ABORT and RESP.
- Reason: the unit clears its timing state when clk_en is low.
REQ-021 ci_start SHALL be 1 only in ISSUE.
REQ-022 ci_done SHALL be ignored outside WAIT.
REQ-023 WAIT SHALL increment the 8-bit wait counter by 1 each cycle.
REQ-024 WAIT with ci_done=1 SHALL take priority over timeout, capture ci_result into rsp_data with rsp_timeout=0, and go to RESP.
REQ-025 WAIT with ci_done=0 on the TIMEOUT-th WAIT cycle SHALL go to ABORT.
REQ-026 ABORT SHALL last one cycle with ci_reset=1, set rsp_data=0 and rsp_timeout=1, and go to RESP.
REQ-027 ci_reset SHALL be 0 in all other states.
REQ-028 RESP SHALL drive rsp_valid=1 and hold rsp_data and rsp_timeout stable until the cycle with rsp_ready=1, then go to IDLE.
REQ-029 rsp_valid SHALL be 0 outside RESP.
REQ-030 rsp_ready while not in RESP SHALL have no effect.
REQ-031 Latency SHALL be: request handshake at cycle 0 -> ci_start at cycle 1 -> ci_done first seen at cycle 1+L -> rsp_valid at cycle 2+L.
REQ-032 At most one operation SHALL be outstanding; there SHALL be no pipelining.
REQ-033 stat_done SHALL increment on the REQ-024 transition and stat_timeout on entry to ABORT.
REQ-034 Both stat counters SHALL saturate at 0xFFFF.
REQ-035 req_valid arriving while busy SHALL be neither accepted nor lost; it waits for IDLE.

Reset
REQ-036 reset SHALL override every state and force IDLE, including mid-WAIT or mid-RESP.
REQ-037 On reset: req_ready=1 in the following cycle; rsp_valid, rsp_timeout, ci_start, ci_clk_en, ci_reset = 0.
REQ-038 On reset: rsp_data, the operand registers, the wait counter, stat_done and stat_timeout = 0.
REQ-039 Reset asserted during WAIT SHALL NOT produce a response, and SHALL NOT increment either stat counter.

Verification
REQ-040 Normal operation: unit model with latency 3; req 0x00000005/0x00000007 at cycle 0 -> ci_start at cycle 1; done at cycle 4 carrying ci_result 0x0000000C -> rsp_valid at cycle 5, rsp_data=0x0000000C, rsp_timeout=0, stat_done=1.
REQ-041 Timeout: unit never asserts done, TIMEOUT=32 -> exactly 32 WAIT cycles, then one cycle with ci_reset=1, then rsp_valid with rsp_data=0, rsp_timeout=1, stat_timeout=1.
REQ-042 Backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data stable throughout, req_ready=0; rsp_ready=1 -> IDLE the next cycle.
REQ-043 Done versus timeout: ci_done=1 on the 32nd WAIT cycle -> normal response with rsp_timeout=0 and no ci_reset pulse.
REQ-044 Reset mid-WAIT: reset at WAIT cycle 2 -> the next cycle shows IDLE, ci_clk_en=0, no rsp_valid, and both stat counters unchanged.
REQ-045 Saturation: stat_done preloaded via 65535 operations -> one more operation leaves stat_done=0xFFFF.
